// File: rtl/cache_bus_arbiter_if.sv
// Handshake bundle between the cache requesters, the arbiter and the
// cache-line bus controller. The arbiter connects through the slave modport;
// whoever drives the requests and bus-controller pulses uses master.
interface cache_bus_arbiter_if #(
    parameter int CONNECTIONS = 2
);
    localparam int ID_W = (CONNECTIONS > 1) ? $clog2(CONNECTIONS) : 1;

    logic [CONNECTIONS-1:0] req;
    logic [CONNECTIONS-1:0] req_store;
    logic                   snoop_busy;
    logic                   bus_accept;
    logic                   txn_done;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_store;
    logic [CONNECTIONS-1:0] grant_onehot;
    logic                   busy;
    logic                   timeout_err;

    modport master (
        output req, req_store, snoop_busy, bus_accept, txn_done,
        input  grant_valid, grant_id, grant_store, grant_onehot, busy, timeout_err
    );

    modport slave (
        input  req, req_store, snoop_busy, bus_accept, txn_done,
        output grant_valid, grant_id, grant_store, grant_onehot, busy, timeout_err
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one cache-line bus controller between several
// caches. A grant is offered, held through the bus transaction, and released
// on completion or forcibly after a timeout. New grants are suppressed while
// a snoop is in progress. All outputs come straight from registers.
module cache_bus_arbiter #(
    parameter int CONNECTIONS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_bus_arbiter_if.slave   bus
);
    localparam int ID_W    = (CONNECTIONS > 1) ? $clog2(CONNECTIONS) : 1;
    // One spare bit so the counter cannot wrap before reaching the compare value.
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ID_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic                   grant_valid_reg, grant_valid_next;
    logic [ID_W-1:0]        grant_id_reg, grant_id_next;
    logic                   grant_store_reg, grant_store_next;
    logic [CONNECTIONS-1:0] grant_onehot_reg, grant_onehot_next;
    logic                   busy_reg, busy_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [TIMER_W-1:0]     timer_reg, timer_next;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [CONNECTIONS-1:0] pick_onehot;
    logic                   pick_store;
    logic                   owner_requesting;
    logic [ID_W-1:0]        rr_after_grant;
    logic                   timer_expired;

    // Search upward from rr_ptr for the first active request, wrapping at the top.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 0; i < CONNECTIONS; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= CONNECTIONS) begin
                idx = idx - CONNECTIONS;
            end
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Decode the chosen index so the store flag can be picked without indexing.
    generate
        for (genvar gi = 0; gi < CONNECTIONS; gi++) begin : g_pick_onehot
            assign pick_onehot[gi] = (pick_id == ID_W'(gi));
        end
    endgenerate

    assign pick_store       = |(bus.req_store & pick_onehot);
    assign owner_requesting = |(bus.req & grant_onehot_reg);
    assign rr_after_grant   = (grant_id_reg == ID_W'(CONNECTIONS - 1)) ? '0 : grant_id_reg + 1'b1;
    assign timer_expired    = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output computation for the grant FSM.
    always_comb begin
        state_next        = state_reg;
        rr_ptr_next       = rr_ptr_reg;
        grant_valid_next  = grant_valid_reg;
        grant_id_next     = grant_id_reg;
        grant_store_next  = grant_store_reg;
        grant_onehot_next = grant_onehot_reg;
        busy_next         = busy_reg;
        timeout_err_next  = 1'b0;
        timer_next        = timer_reg;

        case (state_reg)
            IDLE: begin
                // A pending snoop beats any request arriving in the same cycle.
                if (!bus.snoop_busy && pick_found) begin
                    state_next        = GRANT;
                    grant_valid_next  = 1'b1;
                    grant_id_next     = pick_id;
                    grant_store_next  = pick_store;
                    grant_onehot_next = pick_onehot;
                    busy_next         = 1'b1;
                end
            end
            GRANT: begin
                // Acceptance wins over a simultaneous withdrawal.
                if (bus.bus_accept) begin
                    state_next       = BUSY;
                    grant_valid_next = 1'b0;
                    timer_next       = '0;
                end else if (!owner_requesting) begin
                    // Withdrawal leaves the pointer alone: nobody was served.
                    state_next        = IDLE;
                    grant_valid_next  = 1'b0;
                    grant_id_next     = '0;
                    grant_store_next  = 1'b0;
                    grant_onehot_next = '0;
                    busy_next         = 1'b0;
                end
            end
            BUSY: begin
                timer_next = timer_reg + TIMER_W'(1);
                if (bus.txn_done || timer_expired) begin
                    state_next        = IDLE;
                    rr_ptr_next       = rr_after_grant;
                    grant_valid_next  = 1'b0;
                    grant_id_next     = '0;
                    grant_store_next  = 1'b0;
                    grant_onehot_next = '0;
                    busy_next         = 1'b0;
                    timer_next        = '0;
                    // A completion on the expiry cycle counts as a normal finish.
                    timeout_err_next  = !bus.txn_done;
                end
            end
            default: begin
                state_next        = IDLE;
                grant_valid_next  = 1'b0;
                grant_id_next     = '0;
                grant_store_next  = 1'b0;
                grant_onehot_next = '0;
                busy_next         = 1'b0;
                timer_next        = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            grant_valid_reg  <= 1'b0;
            grant_id_reg     <= '0;
            grant_store_reg  <= 1'b0;
            grant_onehot_reg <= '0;
            busy_reg         <= 1'b0;
            timeout_err_reg  <= 1'b0;
            timer_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            rr_ptr_reg       <= rr_ptr_next;
            grant_valid_reg  <= grant_valid_next;
            grant_id_reg     <= grant_id_next;
            grant_store_reg  <= grant_store_next;
            grant_onehot_reg <= grant_onehot_next;
            busy_reg         <= busy_next;
            timeout_err_reg  <= timeout_err_next;
            timer_reg        <= timer_next;
        end
    end

    assign bus.grant_valid  = grant_valid_reg;
    assign bus.grant_id     = grant_id_reg;
    assign bus.grant_store  = grant_store_reg;
    assign bus.grant_onehot = grant_onehot_reg;
    assign bus.busy         = busy_reg;
    assign bus.timeout_err  = timeout_err_reg;
endmodule
